// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase accumulator and its dither LFSR.
package dds_pkg;

    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } dds_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dds_phase_accumulator_if.sv
// Tuning-word handshake and phase-address output bundle of the DDS accumulator.
interface dds_phase_accumulator_if
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

    logic              ftw_valid;
    logic [ACC_W-1:0]  ftw_data;
    logic              ftw_ready;
    logic [ADDR_W-1:0] address;
    logic              address_valid;
    logic              wrap;

    modport master (
        output ftw_valid, ftw_data,
        input  ftw_ready, address, address_valid, wrap
    );

    modport slave (
        input  ftw_valid, ftw_data,
        output ftw_ready, address, address_valid, wrap
    );

endinterface

// File: rtl/dds_lfsr16.sv
// 16-bit Fibonacci LFSR used as phase-truncation dither source.
module dds_lfsr16
    import dds_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] out
);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LFSR_SEED;
        end else if (advance) begin
            r_state <= {r_state[14:0], ^(r_state & LFSR_TAPS)};
        end
    end

    assign out = r_state;

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator with phase-continuous FTW updates (applied at wrap).
// Optional truncation dither enabled by defining PHASE_DITHER_EN.
module dds_phase_accumulator
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sync_clear,
    input  logic [ADDR_W-1:0]     phase_offset,
    dds_phase_accumulator_if.slave bus
);

    dds_state_e        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_ftw_active;
    logic [ACC_W-1:0]  r_ftw_shadow;
    logic              r_ftw_ready;
    logic [ADDR_W-1:0] r_address;
    logic              r_address_valid;
    logic              r_wrap;

    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic              w_accept;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_addr_src;

    // Accumulator next value: clear beats enable
    always_comb begin
        w_sum      = {1'b0, r_acc} + {1'b0, r_ftw_active};
        w_carry    = w_sum[ACC_W];
        w_accept   = bus.ftw_valid & r_ftw_ready;
        w_acc_next = r_acc;
        if (sync_clear) begin
            w_acc_next = '0;
        end else if (enable) begin
            w_acc_next = w_sum[ACC_W-1:0];
        end
    end

`ifdef PHASE_DITHER_EN
    localparam logic [ACC_W-1:0] DITHER_MASK = (ACC_W'(1) << (ACC_W - ADDR_W)) - ACC_W'(1);

    logic [15:0] w_lfsr;

    dds_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (enable),
        .out     (w_lfsr)
    );

    // Dither only perturbs the address tap, never the accumulator
    assign w_addr_src = w_acc_next + (ACC_W'(w_lfsr) & DITHER_MASK);
`else
    assign w_addr_src = w_acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_acc           <= '0;
            r_ftw_active    <= '0;
            r_ftw_shadow    <= '0;
            r_ftw_ready     <= 1'b1;
            r_address       <= '0;
            r_address_valid <= 1'b0;
            r_wrap          <= 1'b0;
        end else begin
            r_acc           <= w_acc_next;
            r_address       <= w_addr_src[ACC_W-1 -: ADDR_W] + phase_offset;
            r_address_valid <= enable;
            r_wrap          <= enable & w_carry & ~sync_clear;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ftw_active <= bus.ftw_data;
                    end
                    if (enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        if (w_accept) begin
                            r_ftw_active <= bus.ftw_data;
                        end
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        // Held back so the running add finishes its current period
                        r_ftw_shadow <= bus.ftw_data;
                        r_ftw_ready  <= 1'b0;
                        r_state      <= PEND;
                    end
                end
                PEND: begin
                    if (!enable || sync_clear || w_carry) begin
                        r_ftw_active <= r_ftw_shadow;
                        r_ftw_ready  <= 1'b1;
                        r_state      <= enable ? RUN : IDLE;
                    end
                end
                default: begin
                    r_ftw_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ftw_ready     = r_ftw_ready;
    assign bus.address       = r_address;
    assign bus.address_valid = r_address_valid;
    assign bus.wrap          = r_wrap;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator with a per-cycle reference-model scoreboard.
module tb_dds_phase_accumulator;

    typedef struct packed {
        logic [7:0] addr;
        logic       valid;
        logic       wrap;
        logic       ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sync_clear;
    logic [7:0] phase_offset;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    logic [23:0] m_acc, m_active, m_shadow;
    bit          m_pend, m_run;
    logic [7:0]  last_addr;
    bit          wrap_seen;

    dds_phase_accumulator_if #(.ACC_W(24), .ADDR_W(8)) bus ();

    dds_phase_accumulator #(.ACC_W(24), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sync_clear   (sync_clear),
        .phase_offset (phase_offset),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [7:0] obs, input logic [7:0] exp);
`ifdef PHASE_DITHER_EN
        logic [7:0] exp1;
        exp1 = exp + 8'd1;
        checks++;
        assert (obs === exp || obs === exp1) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h(+1)", tag, obs, exp);
        end
`else
        chk(tag, 32'(obs), 32'(exp));
`endif
    endtask

    task automatic model_reset();
        m_acc    = '0;
        m_active = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        m_run    = 1'b0;
        sb.delete();
    endtask

    // Reference behaviour: RUN is "enable was high last cycle and no FTW pending"
    task automatic model_edge(output exp_t e);
        logic [24:0] s;
        logic [23:0] nacc;
        bit          carry;
        s     = {1'b0, m_acc} + {1'b0, m_active};
        carry = s[24];
        nacc  = sync_clear ? 24'h0 : (enable ? s[23:0] : m_acc);
        e.addr  = nacc[23:16] + phase_offset;
        e.valid = enable;
        e.wrap  = enable && carry && !sync_clear;
        if (m_pend) begin
            if (!enable || sync_clear || carry) begin
                m_active = m_shadow;
                m_pend   = 1'b0;
            end
        end else if (bus.ftw_valid) begin
            if (m_run && enable) begin
                m_shadow = bus.ftw_data;
                m_pend   = 1'b1;
            end else begin
                m_active = bus.ftw_data;
            end
        end
        m_acc   = nacc;
        m_run   = enable;
        e.ready = !m_pend;
    endtask

    task automatic step();
        exp_t e;
        model_edge(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_addr("sb_addr", bus.address, e.addr);
        chk("sb_valid", 32'(bus.address_valid), 32'(e.valid));
        chk("sb_wrap",  32'(bus.wrap),          32'(e.wrap));
        chk("sb_ready", 32'(bus.ftw_ready),     32'(e.ready));
        last_addr = e.addr;
        if (bus.wrap) wrap_seen = 1'b1;
    endtask

    task automatic run_to_wrap(input string tag);
        wrap_seen = 1'b0;
        for (int i = 0; i < 300 && !wrap_seen; i++) step();
        chk(tag, 32'(wrap_seen), 32'd1);
    endtask

    task automatic load_ftw_idle(input logic [23:0] ftw);
        enable           = 1'b0;
        bus.ftw_valid    = 1'b1;
        bus.ftw_data     = ftw;
        step();
        bus.ftw_valid    = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        sync_clear    = 1'b0;
        phase_offset  = 8'h00;
        bus.ftw_valid = 1'b0;
        bus.ftw_data  = '0;
        model_reset();
        #12;
        chk("rst_addr",  32'(bus.address),       32'h0);
        chk("rst_valid", 32'(bus.address_valid), 32'h0);
        chk("rst_wrap",  32'(bus.wrap),          32'h0);
        chk("rst_ready", 32'(bus.ftw_ready),     32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Unit step: address +1 per cycle, wrap on address 00 every 256 cycles
        load_ftw_idle(24'h010000);
        enable = 1'b1;
        step();
        chk_addr("t2_first_addr", bus.address, 8'h01);
        repeat (254) step();
        chk_addr("t2_addr_ff", bus.address, 8'hFF);
        chk("t2_no_wrap_early", 32'(bus.wrap), 32'h0);
        step();
        chk_addr("t2_wrap_addr", bus.address, 8'h00);
        chk("t2_wrap", 32'(bus.wrap), 32'h1);

        // FTW change mid-run is deferred to the wrap
        repeat (64) step();
        chk_addr("t3_at_40", bus.address, 8'h40);
        bus.ftw_valid = 1'b1;
        bus.ftw_data  = 24'h020000;
        step();
        bus.ftw_valid = 1'b0;
        chk_addr("t3_still_unit", bus.address, 8'h41);
        chk("t3_ready_low", 32'(bus.ftw_ready), 32'h0);
        run_to_wrap("t3_wrap_seen");
        chk_addr("t3_wrap_addr", bus.address, 8'h00);
        chk("t3_ready_back", 32'(bus.ftw_ready), 32'h1);
        step();
        chk_addr("t3_step2_a", bus.address, 8'h02);
        step();
        chk_addr("t3_step2_b", bus.address, 8'h04);

        // Phase offset: 48,50,58,... and wrap lands on the offset
        enable       = 1'b0;
        phase_offset = 8'h40;
        sync_clear   = 1'b1;
        step();
        sync_clear   = 1'b0;
        chk_addr("t4_clear_addr", bus.address, 8'h40);
        load_ftw_idle(24'h080000);
        enable = 1'b1;
        step();
        chk_addr("t4_seq0", bus.address, 8'h48);
        step();
        chk_addr("t4_seq1", bus.address, 8'h50);
        step();
        chk_addr("t4_seq2", bus.address, 8'h58);
        run_to_wrap("t4_wrap_seen");
        chk_addr("t4_wrap_addr", bus.address, 8'h40);

        // sync_clear on a carry cycle suppresses wrap
        repeat (31) step();
        chk_addr("t5_pre", bus.address, 8'h38);
        sync_clear = 1'b1;
        step();
        sync_clear = 1'b0;
        chk("t5_wrap_suppressed", 32'(bus.wrap), 32'h0);
        chk_addr("t5_addr_offset", bus.address, 8'h40);

        // Dropping enable while pending applies the shadow FTW
        step();
        bus.ftw_valid = 1'b1;
        bus.ftw_data  = 24'h030000;
        step();
        bus.ftw_valid = 1'b0;
        repeat (3) step();
        chk("t6_pending", 32'(bus.ftw_ready), 32'h0);
        begin
            logic [7:0] held;
            held   = last_addr;
            enable = 1'b0;
            step();
            chk("t6_ready", 32'(bus.ftw_ready), 32'h1);
            chk("t6_valid", 32'(bus.address_valid), 32'h0);
            chk_addr("t6_held", bus.address, held);
            enable = 1'b1;
            step();
            chk_addr("t6_new_step", bus.address, held + 8'h03);
        end

        // FTW=0: address frozen, no wrap, pending waits for sync_clear
        load_ftw_idle(24'h000000);
        enable = 1'b1;
        step();
        wrap_seen = 1'b0;
        begin
            logic [7:0] frozen;
            frozen = last_addr;
            repeat (20) step();
            chk_addr("t7_frozen", bus.address, frozen);
        end
        chk("t7_no_wrap", 32'(wrap_seen), 32'h0);
        bus.ftw_valid = 1'b1;
        bus.ftw_data  = 24'h010000;
        step();
        bus.ftw_valid = 1'b0;
        repeat (20) step();
        chk("t7_still_pending", 32'(bus.ftw_ready), 32'h0);
        sync_clear = 1'b1;
        step();
        sync_clear = 1'b0;
        chk("t7_clear_applies", 32'(bus.ftw_ready), 32'h1);
        chk_addr("t7_clear_addr", bus.address, 8'h40);
        step();
        chk_addr("t7_new_ftw", bus.address, 8'h41);

        // Async reset mid-PEND discards the shadow FTW
        phase_offset  = 8'h00;
        bus.ftw_valid = 1'b1;
        bus.ftw_data  = 24'h020000;
        step();
        bus.ftw_valid = 1'b0;
        step();
        chk("t1_pend_before_rst", 32'(bus.ftw_ready), 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t1_async_addr",  32'(bus.address),       32'h0);
        chk("t1_async_wrap",  32'(bus.wrap),          32'h0);
        chk("t1_async_valid", 32'(bus.address_valid), 32'h0);
        chk("t1_async_ready", 32'(bus.ftw_ready),     32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk_addr("t1_shadow_gone", bus.address, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
